// File: rtl/alu_pkg.sv
// Shared definitions for the sequenced ALU: opcodes, FSM encoding and the
// LC-3 condition-code bit positions.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_AND   = 4'd1;
    localparam logic [3:0] ALU_NOT   = 4'd2;
    localparam logic [3:0] ALU_PASSA = 4'd3;
    localparam logic [3:0] ALU_SUB   = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SHL   = 4'd6;
    localparam logic [3:0] ALU_SHR   = 4'd7;
    localparam logic [3:0] ALU_MUL   = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int NZP_N = 2;
    localparam int NZP_Z = 1;
    localparam int NZP_P = 0;

    function automatic logic [2:0] nzp_of(input logic neg, input logic zero);
        logic [2:0] cc;
        cc        = 3'b000;
        cc[NZP_N] = neg;
        cc[NZP_Z] = zero;
        cc[NZP_P] = !neg && !zero;
        return cc;
    endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one partial-product step per cycle,
// WIDTH steps per operation, low WIDTH bits of the product.
module alu_seq_mul #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             running;
    logic [WIDTH-1:0] step_acc;

    // done and product describe the step being taken this cycle, so the
    // caller can register the final sum on the same edge as the last step.
    assign step_acc = acc + (mplier[0] ? mcand : '0);
    assign done     = running && (cnt == CW'(1));
    assign product  = step_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            mcand   <= a;
            mplier  <= b;
            acc     <= '0;
            cnt     <= CW'(WIDTH);
            running <= 1'b1;
        end else if (running) begin
            acc    <= step_acc;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1)) running <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked LC-3 style ALU with registered result and NZP condition codes.
// valid/ready: a transfer happens on a rising edge where both are high.
module alu_seq
    import alu_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [3:0]       ALUK,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT,
    output logic [2:0]       NZP,
    output logic             BUSY,
    output state_t           dbg_state
);
    state_t           state, state_next;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   cnt;
    logic [SHW-1:0]   amt;
    logic             accept, go_exec, finish, load_out;
    logic [WIDTH-1:0] imm_res, shift_next, out_next;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    assign amt       = B[SHW-1:0];
    assign IN_READY  = (state == ST_IDLE) || (state == ST_DONE && OUT_READY);
    assign accept    = IN_VALID && IN_READY;
    assign go_exec   = (ALUK == ALU_MUL) ||
                       ((ALUK == ALU_SHL || ALUK == ALU_SHR) && amt != '0);
    assign OUT_VALID = (state == ST_DONE);
    assign BUSY      = (state == ST_EXEC);
    assign dbg_state = state;

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .start   (accept && ALUK == ALU_MUL),
        .a       (A),
        .b       (B),
        .done    (mul_done),
        .product (mul_product)
    );

    // Shifts with amount 0 fall into the default arm and return A.
    always_comb begin
        imm_res = A;
        case (ALUK)
            ALU_ADD: imm_res = A + B;
            ALU_AND: imm_res = A & B;
            ALU_NOT: imm_res = ~A;
            ALU_SUB: imm_res = A + ~B + WIDTH'(1);
            ALU_XOR: imm_res = A ^ B;
            default: imm_res = A;
        endcase
    end

    assign shift_next = (op_r == ALU_SHL) ? (acc << 1) : (acc >> 1);
    assign finish     = (op_r == ALU_MUL) ? mul_done : (cnt == SHW'(1));
    assign load_out   = (accept && !go_exec) || (state == ST_EXEC && finish);
    assign out_next   = accept ? imm_res :
                        ((op_r == ALU_MUL) ? mul_product : shift_next);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (accept)
                    state_next = go_exec ? ST_EXEC : ST_DONE;
                else if (state == ST_DONE && OUT_READY)
                    state_next = ST_IDLE;
            end
            ST_EXEC: if (finish) state_next = ST_DONE;
            default: state_next = ST_IDLE;
        endcase
    end

    // OUT only changes when a finished result lands; EXEC partials stay in acc.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            OUT  <= '0;
            NZP  <= 3'b010;
            op_r <= ALU_ADD;
            acc  <= '0;
            cnt  <= '0;
        end else begin
            if (accept) begin
                op_r <= ALUK;
                acc  <= A;
                cnt  <= amt;
            end else if (state == ST_EXEC && op_r != ALU_MUL) begin
                acc <= shift_next;
                cnt <= cnt - SHW'(1);
            end
            if (load_out) begin
                OUT <= out_next;
                NZP <= nzp_of(out_next[WIDTH-1], out_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomized checks of alu_seq (WIDTH=16) against an
// arithmetic reference model of each opcode and its latency.
module tb_alu_seq;
    import alu_pkg::*;

    logic        CLK, RESET_N, IN_VALID, IN_READY, OUT_VALID, OUT_READY, BUSY;
    logic [3:0]  ALUK;
    logic [15:0] A, B, OUT;
    logic [2:0]  NZP;
    state_t      dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int last_busy;
    logic [15:0] last_out;

    alu_seq #(.WIDTH(16)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .ALUK(ALUK), .A(A), .B(B), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT(OUT), .NZP(NZP), .BUSY(BUSY), .dbg_state(dbg_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [15:0] ref_result(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        longint ua = a;
        longint ub = b;
        longint amt = b % 16;
        case (op)
            4'd0: return 16'((ua + ub) % 65536);
            4'd1: return a & b;
            4'd2: return ~a;
            4'd4: return 16'((ua + 65536 - ub) % 65536);
            4'd5: return a ^ b;
            4'd6: return 16'((ua * (64'd1 << amt)) % 65536);
            4'd7: return 16'(ua / (64'd1 << amt));
            4'd8: return 16'((ua * ub) % 65536);
            default: return a;
        endcase
    endfunction

    function automatic logic [2:0] ref_nzp(input logic [15:0] r);
        if (r == 0)          return 3'b010;
        else if (r >= 32768) return 3'b100;
        else                 return 3'b001;
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [15:0] b);
        if (op == 4'd8) return 17;
        if (op == 4'd6 || op == 4'd7) return int'(b % 16) + 1;
        return 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int g = 0;
        while (!IN_READY && g < 50) begin
            @(negedge CLK);
            g++;
        end
        check("wait_in_ready", {31'd0, IN_READY}, 32'd1);
    endtask

    // Called on a negedge; returns on a negedge with the block back in IDLE.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input int stall, input string tag);
        logic [15:0] e = ref_result(op, a, b);
        int lat = 1;
        wait_ready();
        IN_VALID  = 1'b1;
        ALUK      = op;
        A         = a;
        B         = b;
        OUT_READY = (stall == 0);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        A = 16'($urandom);
        B = 16'($urandom);
        last_busy = 0;
        @(negedge CLK);
        while (!OUT_VALID && lat < 40) begin
            last_busy += int'(BUSY);
            if (lat == 1 || op == 4'd8) check({tag, "_out_hold_exec"}, OUT, last_out);
            @(negedge CLK);
            lat++;
        end
        check({tag, "_latency"}, lat, ref_lat(op, b));
        check({tag, "_out"}, OUT, e);
        check({tag, "_nzp"}, NZP, ref_nzp(e));
        for (int i = 0; i < stall; i++) begin
            check({tag, "_stall_out"}, OUT, e);
            check({tag, "_stall_ready"}, {IN_READY, OUT_VALID}, 2'b01);
            @(negedge CLK);
        end
        last_out  = e;
        OUT_READY = 1'b1;
        @(negedge CLK);
        check({tag, "_release"}, OUT_VALID, 1'b0);
    endtask

    initial begin
        logic [15:0] ra, rb, e;
        logic [3:0]  rop;
        int pulses, lat;

        RESET_N = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
        ALUK = 4'd0; A = '0; B = '0; last_out = '0;

        @(negedge CLK);
        check("rst_out", OUT, 16'h0000);
        check("rst_nzp", NZP, 3'b010);
        check("rst_flags", {OUT_VALID, BUSY, IN_READY}, 3'b001);
        RESET_N = 1'b1;
        @(negedge CLK);

        // ADD overflowing into the sign bit
        issue(4'd0, 16'h7FFF, 16'h0001, 0, "add_ovf");
        check("add_ovf_ready", IN_READY, 1'b1);

        // SUB then NOT back to back, no bubble
        IN_VALID = 1'b1; ALUK = 4'd4; A = 16'd5; B = 16'd5;
        @(negedge CLK);
        check("b2b_sub_out", {OUT_VALID, IN_READY, OUT}, {2'b11, 16'h0000});
        check("b2b_sub_nzp", NZP, 3'b010);
        ALUK = 4'd2; A = 16'h00FF;
        @(negedge CLK);
        check("b2b_not_out", {OUT_VALID, OUT}, {1'b1, 16'hFF00});
        check("b2b_not_nzp", NZP, 3'b100);
        IN_VALID = 1'b0;
        last_out = 16'hFF00;
        @(negedge CLK);
        check("b2b_idle", OUT_VALID, 1'b0);

        issue(4'd6, 16'h0003, 16'd4, 0, "shl4");
        check("shl4_busy_cycles", last_busy, 4);
        issue(4'd7, 16'hABCD, 16'h0010, 0, "shr0");
        issue(4'd8, 16'h0123, 16'h0045, 0, "mul");

        // MUL with a second request held during EXEC
        wait_ready();
        IN_VALID = 1'b1; ALUK = 4'd8; A = 16'h0123; B = 16'h0045;
        @(posedge CLK);
        #1;
        ALUK = 4'd0; A = 16'd1; B = 16'd2;
        lat = 1;
        @(negedge CLK);
        while (!OUT_VALID && lat < 40) begin
            check("mulhold_in_ready", IN_READY, 1'b0);
            @(negedge CLK);
            lat++;
        end
        check("mulhold_latency", lat, 17);
        check("mulhold_out", OUT, 16'h4E6F);
        @(negedge CLK);
        check("mulhold_next", {OUT_VALID, OUT}, {1'b1, 16'd3});
        IN_VALID = 1'b0;
        last_out = 16'd3;
        @(negedge CLK);

        // Backpressure, with an XOR waiting on IN_VALID
        issue(4'd1, 16'hF0F0, 16'h3C3C, 5, "and_bp");
        OUT_READY = 1'b0;
        IN_VALID = 1'b1; ALUK = 4'd1; A = 16'hF0F0; B = 16'h3C3C;
        @(negedge CLK);
        ALUK = 4'd5; A = 16'h1234; B = 16'h00FF;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("bp_held", {IN_READY, OUT}, {1'b0, 16'h3030});
        end
        OUT_READY = 1'b1;
        @(negedge CLK);
        check("bp_xor", {OUT_VALID, OUT}, {1'b1, 16'h12CB});
        check("bp_xor_nzp", NZP, 3'b001);
        IN_VALID = 1'b0;
        last_out = 16'h12CB;
        @(negedge CLK);

        // Randomized operations against the reference model
        for (int k = 0; k < 40; k++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = 16'($urandom);
            rb  = (k % 4 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            issue(rop, ra, rb, int'($urandom_range(0, 2)), $sformatf("rnd%0d_op%0d", k, rop));
        end

        // Reset in cycle 8 of a MUL
        wait_ready();
        IN_VALID = 1'b1; ALUK = 4'd8; A = 16'h0123; B = 16'h0045;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        for (int i = 0; i < 8; i++) @(negedge CLK);
        check("mid_busy", BUSY, 1'b1);
        RESET_N = 1'b0;
        #1;
        check("mid_rst_out", {OUT, NZP}, {16'h0000, 3'b010});
        check("mid_rst_flags", {OUT_VALID, BUSY, IN_READY}, 3'b001);
        @(negedge CLK);
        RESET_N = 1'b1;
        last_out = 16'h0000;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            pulses += int'(OUT_VALID);
        end
        check("mid_no_pulse", pulses, 0);
        issue(4'd0, 16'd2, 16'd3, 0, "post_rst_add");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
